vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 138 +++++++++++++
 tb/tb_vga_scanout.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : VGA timing generator that scans a 640-wide frame buffer, one pixel
//            per CLK_DIV system clocks. Macro VGA_TEST_PATTERN_EN adds a
//            colour-bar test pattern selected by pattern_sel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        sys_clk,
   input  logic        rst,
   output logic [18:0] raddr_vga,
   input  logic [11:0] rdata_vga,
   input  logic        pattern_sel,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_HW      = $clog2(c_H_TOTAL);
   localparam int c_VW      = $clog2(c_V_TOTAL);

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_HW-1:0]    c_H_LAST   = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_HW-1:0]    c_H_ACT    = c_HW'(H_ACTIVE);
   localparam logic [c_HW-1:0]    c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
   localparam logic [c_HW-1:0]    c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_VW-1:0]    c_V_LAST   = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_VW-1:0]    c_V_ACT    = c_VW'(V_ACTIVE);
   localparam logic [c_VW-1:0]    c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
   localparam logic [c_VW-1:0]    c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [c_DIV_W-1:0] r_div;
   logic [c_HW-1:0]    r_hcnt;
   logic [c_VW-1:0]    r_vcnt;

   logic               w_tick;
   logic               w_h_wrap;
   logic               w_v_wrap;
   logic [c_HW-1:0]    w_hcnt_nxt;
   logic [c_VW-1:0]    w_vcnt_nxt;
   logic               w_active;
   logic               w_nxt_active;
   logic               w_hs;
   logic               w_vs;
   logic [18:0]        w_addr_nxt;
   logic [11:0]        w_pixel;

   always_comb begin
      w_tick     = (r_div == c_DIV_LAST);
      w_h_wrap   = (r_hcnt == c_H_LAST);
      w_v_wrap   = (r_vcnt == c_V_LAST);
      w_hcnt_nxt = w_h_wrap ? '0 : r_hcnt + c_HW'(1);
      w_vcnt_nxt = r_vcnt;
      if (w_h_wrap) begin
         w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + c_VW'(1);
      end
      w_active     = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
      w_nxt_active = (w_hcnt_nxt < c_H_ACT) && (w_vcnt_nxt < c_V_ACT);
      w_hs         = !((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
      w_vs         = !((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));
      // vcnt*640 as vcnt*512 + vcnt*128
      w_addr_nxt   = '0;
      if (w_nxt_active) begin
         w_addr_nxt = 19'({w_vcnt_nxt, 9'b0}) + 19'({w_vcnt_nxt, 7'b0}) + 19'(w_hcnt_nxt);
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]  w_bar;
   logic [11:0] w_bar_rgb;

   always_comb begin
      w_bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (r_hcnt >= c_HW'(80 * i)) w_bar = 3'(i);
      end
      case (w_bar)
         3'd0:    w_bar_rgb = 12'hFFF;
         3'd1:    w_bar_rgb = 12'hFF0;
         3'd2:    w_bar_rgb = 12'h0FF;
         3'd3:    w_bar_rgb = 12'h0F0;
         3'd4:    w_bar_rgb = 12'hF0F;
         3'd5:    w_bar_rgb = 12'hF00;
         3'd6:    w_bar_rgb = 12'h00F;
         default: w_bar_rgb = 12'h000;
      endcase
      w_pixel = pattern_sel ? w_bar_rgb : rdata_vga;
   end
`else
   logic w_unused_pattern_sel;
   assign w_unused_pattern_sel = pattern_sel;
   assign w_pixel              = rdata_vga;
`endif

   // Outputs capture the pixel being left, so they trail the counters by one pixel
   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         r_div                 <= '0;
         r_hcnt                <= '0;
         r_vcnt                <= '0;
         raddr_vga             <= '0;
         vga_hs                <= 1'b1;
         vga_vs                <= 1'b1;
         {vga_r, vga_g, vga_b} <= 12'h000;
         frame_start           <= 1'b0;
      end else begin
         r_div       <= w_tick ? '0 : r_div + c_DIV_W'(1);
         frame_start <= w_tick && w_h_wrap && w_v_wrap;
         if (w_tick) begin
            r_hcnt                <= w_hcnt_nxt;
            r_vcnt                <= w_vcnt_nxt;
            raddr_vga             <= w_addr_nxt;
            vga_hs                <= w_hs;
            vga_vs                <= w_vs;
            {vga_r, vga_g, vga_b} <= w_active ? w_pixel : 12'h000;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Self-checking bench for vga_scanout with a shortened frame and a
//            position-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

   localparam int CD    = 2;
   localparam int HA    = 640;
   localparam int HF    = 16;
   localparam int HS    = 96;
   localparam int HB    = 48;
   localparam int VA    = 4;
   localparam int VF    = 1;
   localparam int VS    = 1;
   localparam int VB    = 1;
   localparam int HT    = HA + HF + HS + HB;
   localparam int VT    = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk         = 1'b0;
   logic        rst         = 1'b0;
   logic        pattern_sel = 1'b0;
   logic [18:0] raddr_vga;
   logic [11:0] rdata_vga;
   logic        vga_hs;
   logic        vga_vs;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        frame_start;

   int   checks   = 0;
   int   errors   = 0;
   int   k        = 0;
   int   cyc      = 0;
   logic sel_tick = 1'b0;
   bit   rand_sel = 1'b1;

   typedef struct {
      int          h;
      int          v;
      logic [18:0] addr;
   } addr_vec_t;

   typedef struct {
      int          x;
      logic [11:0] rgb;
   } pix_vec_t;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                           12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

   vga_scanout #(
      .CLK_DIV (CD),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .sys_clk    (clk),
      .rst        (rst),
      .raddr_vga  (raddr_vga),
      .rdata_vga  (rdata_vga),
      .pattern_sel(pattern_sel),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Frame buffer: each word holds its own address low bits, one-cycle latency
   always @(posedge clk) rdata_vga <= raddr_vga[11:0];

   // Model state: edges since reset release, pattern_sel seen at the latest tick
   always @(posedge clk) begin
      if (!rst) begin
         k <= 0;
      end else begin
         k <= k + 1;
         if ((k + 1) % CD == 0) sel_tick <= pattern_sel;
      end
   end

   always @(negedge clk) begin
      int          t, p, ph, pv, q, qh, qv;
      logic [18:0] e_addr;
      logic        e_hs, e_vs, e_fs;
      logic [11:0] e_rgb;
      t      = k / CD;
      p      = t % FRAME;
      ph     = p % HT;
      pv     = p / HT;
      e_addr = (ph < HA && pv < VA) ? 19'(pv * 640 + ph) : 19'd0;
      e_fs   = (t > 0) && (k % CD == 0) && (p == 0);
      e_hs   = 1'b1;
      e_vs   = 1'b1;
      e_rgb  = 12'h000;
      if (t > 0) begin
         q    = (t - 1) % FRAME;
         qh   = q % HT;
         qv   = q / HT;
         e_hs = !(qh >= HA + HF && qh < HA + HF + HS);
         e_vs = !(qv >= VA + VF && qv < VA + VF + VS);
         if (qh < HA && qv < VA) begin
            e_rgb = 12'(qv * 640 + qh);
`ifdef VGA_TEST_PATTERN_EN
            if (sel_tick) e_rgb = BAR_RGB[qh / 80];
`endif
         end
      end
      checks++;
      if ({raddr_vga, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start} !==
          {e_addr, e_hs, e_vs, e_rgb, e_fs}) begin
         errors++;
         $display("FAIL scan k=%0d: got addr=%0d hs=%b vs=%b rgb=%h fs=%b, expected addr=%0d hs=%b vs=%b rgb=%h fs=%b",
                  k, raddr_vga, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, frame_start,
                  e_addr, e_hs, e_vs, e_rgb, e_fs);
      end
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (rand_sel && $urandom_range(0, 7) == 0) pattern_sel = ~pattern_sel;
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Stop on the first cycle the counters sit at scan position pos
   task automatic wait_pos(input int pos, input string name);
      int n = 0;
      while (!(k > 0 && k % CD == 0 && (k / CD) % FRAME == pos) && n < 2 * FRAME * CD) begin
         step();
         n++;
      end
      if (n >= 2 * FRAME * CD) timeout(name);
   endtask

   task automatic wait_fs(input string name);
      int n = 0;
      while (frame_start !== 1'b1 && n < 2 * FRAME * CD) begin
         step();
         n++;
      end
      if (n >= 2 * FRAME * CD) timeout(name);
   endtask

   task automatic wait_hs(input logic lvl, input string name);
      int n = 0;
      while (vga_hs !== lvl && n < 2 * HT * CD) begin
         step();
         n++;
      end
      if (n >= 2 * HT * CD) timeout(name);
   endtask

   initial begin
      addr_vec_t av [8];
      pix_vec_t  pv [3];
      int        n, n_fs, n_first, c_fs1, c_fall1;

      av[0] = '{h: 5,   v: 0, addr: 19'd5};
      av[1] = '{h: 639, v: 0, addr: 19'd639};
      av[2] = '{h: 640, v: 0, addr: 19'd0};
      av[3] = '{h: 799, v: 0, addr: 19'd0};
      av[4] = '{h: 5,   v: 2, addr: 19'd1285};
      av[5] = '{h: 639, v: 3, addr: 19'd2559};
      av[6] = '{h: 0,   v: 4, addr: 19'd0};
      av[7] = '{h: 320, v: 6, addr: 19'd0};
`ifdef VGA_TEST_PATTERN_EN
      pv[0] = '{x: 0,   rgb: 12'hFFF};
      pv[1] = '{x: 160, rgb: 12'h0FF};
      pv[2] = '{x: 639, rgb: 12'h000};
`else
      pv[0] = '{x: 0,   rgb: 12'h280};
      pv[1] = '{x: 160, rgb: 12'h320};
      pv[2] = '{x: 639, rgb: 12'h4FF};
`endif

      repeat (3) step();
      check("reset_state", {raddr_vga, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start},
            {19'd0, 1'b1, 1'b1, 12'h000, 1'b0});
      rst = 1'b1;

      n = 0;
      while (raddr_vga !== 19'd1 && n < 4 * CD) begin
         step();
         n++;
      end
      check("first_tick", n, CD);

      for (int i = 0; i < 8; i++) begin
         wait_pos(av[i].v * HT + av[i].h, "addr_wait");
         check("addr", raddr_vga, av[i].addr);
      end

      wait_fs("fs1_wait");
      c_fs1 = cyc;
      step();
      check("fs_width", frame_start, 1'b0);

      wait_hs(1'b0, "hs_fall1");
      c_fall1 = cyc;
      check("hs_start_px", ((k / CD) - 1) % HT, HA + HF);
      n = 0;
      while (vga_hs === 1'b0 && n < 2 * HT * CD) begin
         step();
         n++;
      end
      check("hs_low_cycles", n, HS * CD);
      wait_hs(1'b0, "hs_fall2");
      check("line_period", cyc - c_fall1, HT * CD);

      wait_fs("fs2_wait");
      check("frame_period", cyc - c_fs1, FRAME * CD);

      rand_sel    = 1'b0;
      pattern_sel = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_pos(HT + pv[i].x + 1, "pix_wait");
         check("pixel_rgb", {vga_r, vga_g, vga_b}, pv[i].rgb);
      end
      rand_sel = 1'b1;

      wait_pos(2 * HT + 300, "reset_pos");
      rst = 1'b0;
      step();
      check("mid_reset", {raddr_vga, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start},
            {19'd0, 1'b1, 1'b1, 12'h000, 1'b0});
      rst = 1'b1;
      n_fs    = 0;
      n_first = -1;
      for (int i = 1; i <= FRAME * CD + 4; i++) begin
         step();
         if (i == CD) check("restart_addr", raddr_vga, 19'd1);
         if (frame_start === 1'b1) begin
            n_fs++;
            if (n_first < 0) n_first = i;
         end
      end
      check("fs_count_after_reset", n_fs, 1);
      check("fs_delay_after_reset", n_first, FRAME * CD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(100000 * 10);
      errors++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
